ssd_scan_driver: RTL

- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Holds an N-nibble hex value and scans it one digit at a time at a programmable refresh rate, driving the shared segment/dp lines and one active-low anode per digit.
- Adds per-digit blanking, decimal points, optional leading-zero suppression, and tear-free loading: new values take effect only at frame boundaries, with an acknowledge.
- Sits between system logic and board pins.

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/ssd_scan_driver_hex_to_seg.sv | 33 +++
 rtl/ssd_scan_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are a..g on bits [6]..[0], active-low (0 = lit).
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0001100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Decode the nibble into its a..g segment pattern.
  always_comb begin
    // NOTE: assign a default before the case so no path can leave seg unassigned and infer a latch.
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A prescaler produces one tick every REFRESH_DIV cycles; each tick moves the
// scan to the next digit. Loads are buffered and only committed when the scan
// wraps to digit 0, so a frame never mixes old and new data.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   valueIn,
  input  logic [NUM_DIGITS-1:0]     dpIn,
  input  logic [NUM_DIGITS-1:0]     blankIn,
  input  logic                      loadIn,
  output logic                      loadAck,
  output logic [6:0]                sevenOut,
  output logic                      dpOut,
  output logic [NUM_DIGITS-1:0]     anodeOut,
  output logic                      frameStart
);

  localparam int IW = width_for(NUM_DIGITS);
  localparam int PW = width_for(REFRESH_DIV);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         index;
  logic [IW-1:0]         index_nxt;
  logic                  tick;
  logic                  boundary;
  logic                  commit;

  logic [VW-1:0]         pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_flag;

  logic [VW-1:0]         disp_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_blank;

  logic [VW-1:0]         eff_value;
  logic [NUM_DIGITS-1:0] eff_dp;
  logic [NUM_DIGITS-1:0] eff_blank;
  logic [3:0]            nibble;
  logic [6:0]            seg_enc;
  logic                  upper_zero;
  logic                  digit_blank;
  logic [6:0]            seven_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  assign tick      = (presc == PRESC_LAST);
  assign index_nxt = (index == IDX_LAST) ? '0 : index + IW'(1);
  assign boundary  = tick && (index_nxt == '0);
  assign commit    = boundary && pend_flag;

  // Free-running prescaler that wraps at REFRESH_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Digit index; starts at the last digit so the first tick selects digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= IDX_LAST;
    end else if (tick) begin
      index <= index_nxt;
    end
  end

  // Pending buffer: latest load wins; a load on the commit cycle re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are reset too, because a cleared display is visible behaviour here.
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
    end else begin
      if (commit) begin
        pend_flag <= 1'b0;
      end
      if (loadIn) begin
        pend_value <= valueIn;
        pend_dp    <= dpIn;
        pend_blank <= blankIn;
        pend_flag  <= 1'b1;
      end
    end
  end

  // Displayed data, replaced only at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (commit) begin
      disp_value <= pend_value;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
    end
  end

  // Render the digit about to be selected, bypassing freshly committed data.
  always_comb begin
    eff_value = commit ? pend_value : disp_value;
    eff_dp    = commit ? pend_dp    : disp_dp;
    eff_blank = commit ? pend_blank : disp_blank;
    nibble    = eff_value[4*index_nxt +: 4];

    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(index_nxt) && eff_value[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    digit_blank = eff_blank[index_nxt] ||
                  ((LZ_SUPPRESS != 0) && (index_nxt != '0) && upper_zero);

    seven_nxt = SEG_BLANK;
    dp_nxt    = 1'b1;
    anode_nxt = '1;
    if (!digit_blank) begin
      seven_nxt = seg_enc;
      dp_nxt    = ~eff_dp[index_nxt];
      for (int j = 0; j < NUM_DIGITS; j++) begin
        anode_nxt[j] = (j == int'(index_nxt)) ? 1'b0 : 1'b1;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_enc)
  );

  // Output registers: pins change only on ticks; pulses last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sevenOut   <= SEG_BLANK;
      dpOut      <= 1'b1;
      anodeOut   <= '1;
      loadAck    <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      loadAck    <= commit;
      frameStart <= boundary;
      if (tick) begin
        sevenOut <= seven_nxt;
        dpOut    <= dp_nxt;
        anodeOut <= anode_nxt;
      end
    end
  end

endmodule
